// File: rtl/serial_loader_pkg.sv
// serial_loader_pkg: shared frame geometry and FSM states for the serial frame loader.
package serial_loader_pkg;
  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;
  localparam int FRAME_LEN = ADDR_W + DATA_W + 1;
  localparam int ADDR_LSB  = 0;
  localparam int DATA_LSB  = 4;
  localparam int PAR_BIT   = 12;
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_e;
endpackage

// File: rtl/frame_hold_reg.sv
// frame_hold_reg: single-entry valid/ready holding register; free is high when a load
// this cycle cannot clobber an unconsumed entry.
module frame_hold_reg #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         out_ready,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         free
);
  logic [W-1:0] dout_q, dout_d;
  logic         valid_q, valid_d;
  always_comb begin
    free    = ~valid_q | out_ready;
    valid_d = load ? 1'b1 : valid_q & ~out_ready;
    dout_d  = load ? din : dout_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end
  assign dout  = dout_q;
  assign valid = valid_q;
endmodule

// File: rtl/serial_frame_loader.sv
// serial_frame_loader: deserializes LSB-first addr/data/parity frames, checks even parity
// and hands good frames to a single-entry valid/ready holding register.
module serial_frame_loader
  import serial_loader_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sdi,
  input  logic              sdi_valid,
  input  logic              frame_sync,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              parity_err,
  output logic              overflow,
  input  logic              clear_err
);
  localparam int         FL   = ADDR_W + DATA_W + 1;
  localparam logic [3:0] LAST = 4'(FL - 1);
  state_e        state_q, state_d;
  logic [3:0]    bcnt_q, bcnt_d, idx;
  logic [FL-1:0] sr_q, sr_d;
  logic          perr_q, perr_d, ovf_q, ovf_d;
  logic          check, par_ok, free, load, done;
  // A bit sampled during CHECK is bit 0 of the next frame; the checked frame is still in sr_q.
  always_comb begin
    state_d = (state_q == CHECK) ? IDLE : state_q;
    bcnt_d  = bcnt_q;
    sr_d    = sr_q;
    idx     = frame_sync ? 4'd0 : bcnt_q;
    done    = !frame_sync && bcnt_q == LAST;
    if (sdi_valid) begin
      sr_d[idx] = sdi;
      state_d   = done ? CHECK : SHIFT;
      bcnt_d    = done ? 4'd0 : idx + 4'd1;
    end
    check  = state_q == CHECK;
    par_ok = ~^sr_q;
    load   = check & par_ok & free;
    perr_d = (perr_q & ~clear_err) | (check & ~par_ok);
    ovf_d  = (ovf_q & ~clear_err) | (check & par_ok & ~free);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      sr_q    <= '0;
      perr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      sr_q    <= sr_d;
      perr_q  <= perr_d;
      ovf_q   <= ovf_d;
    end
  end
  frame_hold_reg #(.W(DATA_W + ADDR_W)) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .din       ({sr_q[DATA_LSB +: DATA_W], sr_q[ADDR_LSB +: ADDR_W]}),
    .out_ready (out_ready),
    .dout      ({data, addr}),
    .valid     (out_valid),
    .free      (free)
  );
  assign parity_err = perr_q;
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_serial_frame_loader.sv
// tb_serial_frame_loader: scoreboard bench; a bit-list reference model predicts frames and
// flags, a negedge monitor compares the DUT against it.
module tb_serial_frame_loader;
  logic       clk = 0, rst_n = 0;
  logic       sdi = 0, sdi_valid = 0, frame_sync = 0, out_ready = 0, clear_err = 0;
  logic [7:0] data;
  logic [3:0] addr;
  logic       out_valid, parity_err, overflow;
  int         n_chk = 0, n_fail = 0;
  bit         done = 0, rnd_ready = 0;

  serial_frame_loader #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .sdi(sdi), .sdi_valid(sdi_valid), .frame_sync(frame_sync),
    .data(data), .addr(addr), .out_valid(out_valid), .out_ready(out_ready),
    .parity_err(parity_err), .overflow(overflow), .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  // Reference model: collects received bits into a list; a completed 13-bit frame is
  // judged one clock later against a one-deep holding slot.
  logic [11:0] exp_q[$];
  bit          mheld, mperr, movf, pend;
  logic [12:0] fbuf, fdone;
  int          nbits;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mheld = 0; mperr = 0; movf = 0; pend = 0; nbits = 0;
    end else begin : model
      bit pe, oe, fr;
      pe = 0; oe = 0;
      fr = !mheld || out_ready;
      if (mheld && out_ready) mheld = 0;
      if (pend) begin
        if (^fdone) pe = 1;
        else if (fr) begin exp_q.push_back(fdone[11:0]); mheld = 1; end
        else oe = 1;
      end
      pend = 0;
      mperr = (mperr && !clear_err) || pe;
      movf  = (movf && !clear_err) || oe;
      if (sdi_valid) begin
        if (frame_sync) nbits = 0;
        fbuf[nbits] = sdi;
        nbits++;
        if (nbits == 13) begin pend = 1; fdone = fbuf; nbits = 0; end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  int rd = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", {data, addr, out_valid, parity_err, overflow}, 0);
      rd = exp_q.size();
    end else begin
      chk("out_valid", out_valid, mheld);
      chk("parity_err", parity_err, mperr);
      chk("overflow", overflow, movf);
      if (out_valid) begin
        if (rd >= exp_q.size()) chk("unexpected_frame", {data, addr}, 'hFFFF);
        else chk("frame", {data, addr}, exp_q[rd]);
        if (out_ready) rd++;
      end
    end
    if (done) begin
      chk("drain", exp_q.size() - rd, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  task automatic drive(input logic v, input logic b, input logic s, input logic c);
    sdi_valid = v; sdi = b; frame_sync = s; clear_err = c;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    sdi_valid = 0; frame_sync = 0; clear_err = 0;
  endtask

  task automatic send_frame(input logic [3:0] a, input logic [7:0] d, input bit bad,
                            input bit sync, input bit gaps);
    logic [12:0] f;
    f = {(^{d, a}) ^ bad, d, a};
    for (int i = 0; i < 13; i++) begin
      while (gaps && $urandom_range(0, 3) == 0) drive(0, 0, 0, 0);
      drive(1, f[i], sync && i == 0, 0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    out_ready = 1;
    send_frame(4'hA, 8'h5C, 0, 0, 0);
    idle(3);
    send_frame(4'hA, 8'h5C, 1, 0, 0);
    idle(4);
    drive(0, 0, 0, 1);
    idle(2);
    out_ready = 0;
    send_frame(4'h1, 8'h11, 0, 0, 0);
    send_frame(4'h2, 8'h22, 0, 0, 0);
    idle(4);
    out_ready = 1;
    idle(3);
    drive(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) drive(1, 1'($urandom_range(0, 1)), 0, 0);
    send_frame(4'h3, 8'hFF, 0, 1, 0);
    idle(3);
    out_ready = 0;
    send_frame(4'h6, 8'h9D, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive(1, 1'($urandom_range(0, 1)), 0, 0);
    rst_n = 0;
    idle(2);
    rst_n = 1;
    out_ready = 1;
    send_frame(4'h5, 8'hA7, 0, 0, 0);
    idle(2);
    send_frame(4'h7, 8'h3C, 1, 0, 0);
    drive(0, 0, 0, 1);
    idle(3);
    send_frame(4'h8, 8'h81, 0, 0, 0);
    send_frame(4'h9, 8'h42, 0, 0, 0);
    send_frame(4'hC, 8'hE1, 0, 0, 0);
    idle(2);
    rnd_ready = 1;
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 4) == 0)
        for (int i = 0; i < $urandom_range(1, 11); i++) drive(1, 1'($urandom_range(0, 1)), 0, 0);
      send_frame(4'($urandom), 8'($urandom), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) == 0) drive(0, 0, 0, 1);
    end
    rnd_ready = 0;
    out_ready = 1;
    idle(5);
    done = 1;
  end
endmodule
